// File: rtl/start_dip_pkg.sv
// -----------------------------------------------------------------------------
// start_dip_pkg
// Shared types and helpers for the start/DIP input conditioner and the
// wire-buffer sequencer downstream of it.
//   start_state_e : debounce FSM states for the start pushbutton
//   is_legal_dip  : returns 1 for the seven DIP codes the sequencer accepts
// -----------------------------------------------------------------------------
package start_dip_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } start_state_e;

    // Legal codes are 0010 through 1000 inclusive.
    function automatic logic is_legal_dip(input logic [3:0] code);
        logic legal;
        case (code)
            4'b0010: legal = 1'b1;
            4'b0011: legal = 1'b1;
            4'b0100: legal = 1'b1;
            4'b0101: legal = 1'b1;
            4'b0110: legal = 1'b1;
            4'b0111: legal = 1'b1;
            4'b1000: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/start_dip_conditioner_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser for one asynchronous input bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, loads RESET_VAL into every stage
//   d   : asynchronous input
//   q   : synchronised output (last stage of the chain)
// -----------------------------------------------------------------------------
module bit_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw bit through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/start_dip_conditioner.sv
// -----------------------------------------------------------------------------
// start_dip_conditioner
// Synchronises and debounces the active-low start pushbutton and the 4-bit
// DIP switch bank. An accepted press gives a one-cycle start_pulse when the
// current debounced DIP code is legal, otherwise a one-cycle start_reject.
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   start_n      : raw pushbutton, low = pressed (asynchronous)
//   dip_raw      : raw DIP switches (asynchronous)
//   start_pulse  : one-cycle strobe, press accepted with a legal code
//   start_reject : one-cycle strobe, press accepted with an illegal code
//   dip_code     : debounced DIP value
//   dip_valid    : dip_code is one of the legal codes
//   dip_changed  : one-cycle strobe whenever dip_code is reloaded
// -----------------------------------------------------------------------------
module start_dip_conditioner
    import start_dip_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_n,
    input  logic [3:0] dip_raw,
    output logic       start_pulse,
    output logic       start_reject,
    output logic [3:0] dip_code,
    output logic       dip_valid,
    output logic       dip_changed
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             start_sync;
    logic [3:0]       dip_sync;

    start_state_e     state;
    start_state_e     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;
    logic             reject_nxt;

    logic [3:0]       cand;
    logic [CNT_W-1:0] dcnt;

    // Released level is 1 so a reset never looks like a press.
    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_start_sync (
        .clk (clk),
        .rst (rst),
        .d   (start_n),
        .q   (start_sync)
    );

    for (genvar i = 0; i < 4; i++) begin : g_dip_sync
        bit_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (1'b0)
        ) u_dip_sync (
            .clk (clk),
            .rst (rst),
            .d   (dip_raw[i]),
            .q   (dip_sync[i])
        );
    end

    // Start FSM next-state, counter and strobe decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pulse_nxt  = 1'b0;
        reject_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (!start_sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (start_sync) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    // Uses dip_valid as registered before this edge, so a
                    // DIP reload on the same edge cannot affect this press.
                    state_nxt  = PRESSED;
                    pulse_nxt  = dip_valid;
                    reject_nxt = !dip_valid;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (start_sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ZERO;
                end else begin
                    state_nxt = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (!start_sync) begin
                    // Release bounce: back to held, no new strobe.
                    state_nxt = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // Start FSM state, counter and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= CNT_ZERO;
            start_pulse  <= 1'b0;
            start_reject <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            start_pulse  <= pulse_nxt;
            start_reject <= reject_nxt;
        end
    end

    // DIP debounce: candidate tracking, saturating stability counter and
    // reload of the published code once the candidate has been stable long
    // enough and differs from what is currently published.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand        <= 4'b0000;
            dcnt        <= CNT_ZERO;
            dip_code    <= 4'b0000;
            dip_valid   <= 1'b0;
            dip_changed <= 1'b0;
        end else begin
            if (dip_sync != cand) begin
                cand <= dip_sync;
                dcnt <= CNT_ZERO;
            end else if (dcnt != CNT_MAX) begin
                dcnt <= dcnt + CNT_ONE;
            end else begin
                dcnt <= dcnt;
            end

            if ((dcnt == CNT_MAX) && (cand != dip_code)) begin
                dip_code    <= cand;
                dip_valid   <= is_legal_dip(cand);
                dip_changed <= 1'b1;
            end else begin
                dip_changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_start_dip_conditioner.sv
// -----------------------------------------------------------------------------
// tb_start_dip_conditioner
// Directed scenarios plus randomized stimulus for start_dip_conditioner,
// checked every cycle against a reference model. The model keeps a window of
// recent raw samples: a debounced level flips when the synchronised samples
// have held the opposite level for DEB+1 consecutive edges, and the DIP code
// reloads when the last DEB synchronised samples agree and differ from it.
// -----------------------------------------------------------------------------
module tb_start_dip_conditioner;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int HN   = SYNC + DEB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_n;
    logic [3:0] dip_raw;
    logic       start_pulse;
    logic       start_reject;
    logic [3:0] dip_code;
    logic       dip_valid;
    logic       dip_changed;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic       h_start [HN];
    logic [3:0] h_dip   [HN];
    logic       m_level;            // 1 = debounced pressed
    logic [3:0] m_code;
    logic       m_valid;
    logic       m_pulse;
    logic       m_reject;
    logic       m_changed;

    // scenario counters
    int  n_pulse;
    int  n_reject;
    int  n_changed;
    bit  race_seen;

    start_dip_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_n      (start_n),
        .dip_raw      (dip_raw),
        .start_pulse  (start_pulse),
        .start_reject (start_reject),
        .dip_code     (dip_code),
        .dip_valid    (dip_valid),
        .dip_changed  (dip_changed)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic legal_ref(input logic [3:0] c);
        return (c >= 4'd2) && (c <= 4'd8);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) begin
            h_start[i] = 1'b1;
            h_dip[i]   = 4'b0000;
        end
        m_level   = 1'b0;
        m_code    = 4'b0000;
        m_valid   = 1'b0;
        m_pulse   = 1'b0;
        m_reject  = 1'b0;
        m_changed = 1'b0;
    endtask

    // Advance the model by one clock edge that sampled (s, d).
    task automatic model_edge(input logic s, input logic [3:0] d);
        logic old_valid;
        bit   flip;
        bit   settle;
        for (int i = HN - 1; i > 0; i--) begin
            h_start[i] = h_start[i-1];
            h_dip[i]   = h_dip[i-1];
        end
        h_start[0] = s;
        h_dip[0]   = d;
        old_valid  = m_valid;
        m_pulse    = 1'b0;
        m_reject   = 1'b0;
        m_changed  = 1'b0;

        // released (level 0) needs start_n low, pressed (level 1) needs high
        flip = 1'b1;
        for (int i = SYNC; i <= SYNC + DEB; i++)
            if (h_start[i] != m_level) flip = 1'b0;
        if (flip) begin
            if (!m_level) begin
                m_pulse  = old_valid;
                m_reject = !old_valid;
            end
            m_level = !m_level;
        end

        settle = 1'b1;
        for (int i = SYNC + 1; i <= SYNC + DEB; i++)
            if (h_dip[i] != h_dip[SYNC+1]) settle = 1'b0;
        if (settle && (h_dip[SYNC+1] != m_code)) begin
            m_code    = h_dip[SYNC+1];
            m_valid   = legal_ref(m_code);
            m_changed = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_val("start_pulse",  {3'b000, start_pulse},  {3'b000, m_pulse});
        check_val("start_reject", {3'b000, start_reject}, {3'b000, m_reject});
        check_val("dip_code",     dip_code,               m_code);
        check_val("dip_valid",    {3'b000, dip_valid},    {3'b000, m_valid});
        check_val("dip_changed",  {3'b000, dip_changed},  {3'b000, m_changed});
    endtask

    // One clock: drive at negedge, model the posedge, check 1 time unit later.
    task automatic step(input logic s, input logic [3:0] d);
        start_n = s;
        dip_raw = d;
        @(posedge clk);
        model_edge(s, d);
        #1;
        check_outputs();
        if (start_pulse)  n_pulse++;
        if (start_reject) n_reject++;
        if (dip_changed)  n_changed++;
        if (start_pulse && dip_changed) race_seen = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input logic s, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) step(s, d);
    endtask

    task automatic clear_counts();
        n_pulse   = 0;
        n_reject  = 0;
        n_changed = 0;
        race_seen = 1'b0;
    endtask

    // Assert reset between edges, check outputs at once, release after an edge.
    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check_val("rst_code", dip_code, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start_n = 1'b1;
        dip_raw = 4'b0000;
        model_reset();
        clear_counts();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-operation and quiet period after release
        run(1'b0, 4'b0100, 3);
        @(posedge clk);
        #2;
        apply_reset();
        clear_counts();
        run(1'b1, 4'b0000, 20);
        check_val("quiet_strobes", 4'(n_pulse + n_reject + n_changed), 4'd0);

        // DIP settle
        clear_counts();
        run(1'b1, 4'b0100, 10);
        check_val("settle_code", dip_code, 4'b0100);
        check_val("settle_valid", {3'b000, dip_valid}, 4'd1);
        check_val("settle_changes", 4'(n_changed), 4'd1);
        run(1'b1, 4'b1111, 10);
        check_val("illegal_valid", {3'b000, dip_valid}, 4'd0);

        // clean press with legal code, held for 20 cycles
        run(1'b1, 4'b0100, 10);
        clear_counts();
        run(1'b0, 4'b0100, 20);
        run(1'b1, 4'b0100, 10);
        check_val("clean_pulses", 4'(n_pulse), 4'd1);

        // press bounce, then release bounce inside the release window
        clear_counts();
        for (int k = 0; k < 3; k++) begin
            run(1'b0, 4'b0100, 2);
            run(1'b1, 4'b0100, 1);
        end
        run(1'b1, 4'b0100, 10);
        check_val("bounce_strobes", 4'(n_pulse + n_reject), 4'd0);
        run(1'b0, 4'b0100, 10);
        run(1'b1, 4'b0100, 2);
        run(1'b0, 4'b0100, 1);
        run(1'b1, 4'b0100, 10);
        check_val("release_bounce", 4'(n_pulse), 4'd1);

        // illegal press right after reset (code 0000)
        apply_reset();
        clear_counts();
        run(1'b0, 4'b0000, 10);
        run(1'b1, 4'b0000, 10);
        check_val("illegal_reject", 4'(n_reject), 4'd1);
        check_val("illegal_pulse", 4'(n_pulse), 4'd0);

        // race: press acceptance and DIP reload on the same edge
        run(1'b1, 4'b0100, 10);
        clear_counts();
        run(1'b0, 4'b1111, 10);
        check_val("race_both", {3'b000, race_seen}, 4'd1);
        check_val("race_valid", {3'b000, dip_valid}, 4'd0);
        run(1'b1, 4'b1111, 10);

        // randomized hold lengths around the debounce threshold
        begin
            logic       s_cur = 1'b1;
            logic [3:0] d_cur = 4'b0100;
            int         s_left = 0;
            int         d_left = 0;
            for (int c = 0; c < 3000; c++) begin
                if (s_left == 0) begin
                    s_cur  = ~s_cur;
                    s_left = $urandom_range(1, 9);
                end
                if (d_left == 0) begin
                    d_cur  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(2, 8));
                    d_left = $urandom_range(1, 10);
                end
                if ($urandom_range(0, 499) == 0) begin
                    apply_reset();
                end else begin
                    step(s_cur, d_cur);
                end
                s_left--;
                d_left--;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
